lag_subtractor: RTL and testbench
=================================

# lag_subtractor

Streaming signed lag-difference unit for the EEG front end of the seizure-detection CNN. It is the inverse of the accumulate path: it removes slow baseline drift before the first convolution layer. Each accepted 8-bit signed sample x[n] produces the 16-bit signed result y[n] = x[n] − x[n−L], where L is a run-time lag of 0..MAX_LAG. Input and output use a valid/ready handshake. The block sits between the sample buffer and the conv-layer input FIFO.

## Interface
- DATA_W, 8, input sample width, two's complement.
- OUT_W, 16, output width; the result is sign-extended to this width.
- MAX_LAG, 16, history depth and maximum lag.
- DEFAULT_LAG, 1, lag value loaded by reset.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous flush; also latches `lag`.
- lag  input  5  requested lag; sampled only when `clear`=1.
- in_valid  input  1  a sample is offered.
- in_ready  output  1  the block can accept a sample this cycle.
- in_data  input  DATA_W  signed sample x[n].
- out_valid  output  1  `out_data` holds a valid result.
- out_ready  input  1  downstream accepts the result.
- out_data  output  OUT_W  signed y[n].
- out_warm  output  1  y[n] was computed from real history, not zero fill.

## Operation
- History is a register array of MAX_LAG entries with write pointer `wptr`, range 0..MAX_LAG−1. `wptr` wraps from MAX_LAG−1 to 0.
- Effective lag lag_r = min(lag, MAX_LAG), latched when `clear`=1.
- Fill counter `fill` counts accepted samples and saturates at MAX_LAG.
- Transfer on the input side: in_valid && in_ready. On each transfer:
  - Read subtrahend s from index (wptr − lag_r) mod MAX_LAG, before this cycle's write. For lag_r = MAX_LAG this is the old content of `wptr`.
  - s = 0 if lag_r = 0 or fill < lag_r.
  - Register out_data = sext(x) − sext(s). The difference is computed at DATA_W+1 bits, then sign-extended to OUT_W. No saturation is possible.
  - Register out_warm = (lag_r ≠ 0) && (fill ≥ lag_r).
  - Write x to hist[wptr], advance `wptr`, increment `fill` (saturating).
- in_ready = !clear && (!out_valid || out_ready). This gives a single-stage pipeline with full throughput under backpressure-free flow.
- out_valid is set on an input transfer. It clears on an output transfer (out_valid && out_ready) that has no simultaneous input transfer.
- While out_valid=1 and out_ready=0, out_data and out_warm are held stable.
- clear (synchronous, highest priority):
  - Effects: wptr=0, fill=0, out_valid=0, lag_r latched. Any pending output is dropped.
  - An in_valid in the same cycle is not accepted.
  - History contents are left as-is; `fill` masks them.

## Timing
- Reset values (asynchronous on rst_n=0): out_valid=0, out_data=0, out_warm=0, wptr=0, fill=0, lag_r=DEFAULT_LAG, in_ready=1 after release. History contents are don't-care.
- Latency is 1 cycle: a sample accepted at edge k is visible on out_data/out_valid after edge k.
- Throughput is 1 sample/cycle while out_ready=1.
- Simultaneous output drain and new input in the same cycle: out_valid stays 1 and out_data updates to the new result.
- Reset asserted mid-stream discards everything. The first post-reset samples use zero fill, with DEFAULT_LAG.
- A lag change takes effect only through `clear`. The cycle after `clear`, in_ready=1 unless downstream is stalled.

## Test plan
- Reset, then stream 5,7,−3,100 with lag_r=1 and out_ready=1:
  - y = 5,2,−10,103.
  - out_warm = 0,1,1,1.
  - One-cycle latency, in_ready constantly 1.
- clear with lag=3, then stream 1..8:
  - y = 1,2,3,3,3,3,3,3.
  - out_warm goes high from the 4th output.
- Extremes at lag 1: −128 then 127 gives y = −128, then 255 (0x00FF); 127 then −128 gives −255 (0xFF01). This checks sign extension to 16 bits.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1.
  - in_ready=0 and out_data stable.
  - Releasing out_ready accepts the next sample in the same cycle; no sample is lost or duplicated.
- Wrap and clamp:
  - lag=20 is clamped to 16; stream 0..39. Outputs 16..39 equal 16, covering the `wptr` wrap twice.
  - lag=0 passes samples through with out_warm=0.
- Mid-stream events:
  - clear asserted together with in_valid: the sample is not accepted, out_valid drops, and the next output restarts zero fill.
  - rst_n pulsed asynchronously between edges: all outputs read 0 immediately.

Source files
------------

// File: rtl/lag_subtractor.sv
// -----------------------------------------------------------------------------
// lag_subtractor
// Streaming signed lag-difference unit: y[n] = x[n] - x[n-L].
// Removes slow baseline drift from EEG samples ahead of the first conv layer.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clear      synchronous flush (pointer, fill, output) and lag latch
//   lag        requested lag, sampled only while clear=1 (clamped to MAX_LAG)
//   in_valid   / in_ready / in_data    input sample handshake, x[n]
//   out_valid  / out_ready / out_data  result handshake, y[n] sign-extended
//   out_warm   result used real history rather than zero fill
// -----------------------------------------------------------------------------
module lag_subtractor #(
  parameter int DATA_W      = 8,
  parameter int OUT_W       = 16,
  parameter int MAX_LAG     = 16,
  parameter int DEFAULT_LAG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic [4:0]        lag,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_warm
);

  localparam int PTR_W = (MAX_LAG > 1) ? $clog2(MAX_LAG) : 1;
  // Wide enough to hold wptr + MAX_LAG without overflow.
  localparam int SUM_W = PTR_W + 2;

  localparam logic [4:0]       MAX_LAG_L = 5'(MAX_LAG);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(MAX_LAG - 1);
  localparam logic [SUM_W-1:0] MAX_LAG_S = SUM_W'(MAX_LAG);

  logic [DATA_W-1:0] hist [MAX_LAG];
  logic [PTR_W-1:0]  wptr;
  logic [4:0]        fill;
  logic [4:0]        lag_r;

  logic              in_xfer;
  logic              warm;
  logic [SUM_W-1:0]  idx_raw;
  logic [SUM_W-1:0]  idx_mod;
  logic [PTR_W-1:0]  rd_idx;
  logic [DATA_W-1:0] sub;
  logic [DATA_W:0]   diff;
  logic [OUT_W-1:0]  diff_ext;
  logic [4:0]        lag_clamped;

  assign in_ready = !clear && (!out_valid || out_ready);
  assign in_xfer  = in_valid && in_ready;

  // Subtrahend index (wptr - lag_r) mod MAX_LAG, formed without going
  // negative. lag_r = MAX_LAG lands on wptr itself, i.e. the oldest entry,
  // which is read before this cycle's write overwrites it.
  always_comb begin
    idx_raw = SUM_W'(wptr) + MAX_LAG_S - SUM_W'(lag_r);
    idx_mod = (idx_raw >= MAX_LAG_S) ? (idx_raw - MAX_LAG_S) : idx_raw;
    rd_idx  = idx_mod[PTR_W-1:0];
  end

  // History older than the fill count is stale (clear does not wipe it),
  // so the subtrahend is forced to zero until enough samples have arrived.
  assign warm = (lag_r != 5'd0) && (fill >= lag_r);
  assign sub  = warm ? hist[rd_idx] : '0;

  // One extra bit makes the difference of two DATA_W signed values exact.
  assign diff     = {in_data[DATA_W-1], in_data} - {sub[DATA_W-1], sub};
  assign diff_ext = {{(OUT_W-DATA_W-1){diff[DATA_W]}}, diff};

  assign lag_clamped = (lag > MAX_LAG_L) ? MAX_LAG_L : lag;

  // History is not reset; the fill counter masks whatever it holds.
  always_ff @(posedge clk) begin
    if (in_xfer) begin
      hist[wptr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      fill      <= '0;
      lag_r     <= 5'(DEFAULT_LAG);
      out_valid <= 1'b0;
      out_data  <= '0;
      out_warm  <= 1'b0;
    end else if (clear) begin
      wptr      <= '0;
      fill      <= '0;
      lag_r     <= lag_clamped;
      out_valid <= 1'b0;
    end else if (in_xfer) begin
      out_valid <= 1'b1;
      out_data  <= diff_ext;
      out_warm  <= warm;
      wptr      <= (wptr == LAST_PTR) ? '0 : (wptr + 1'b1);
      fill      <= (fill == MAX_LAG_L) ? fill : (fill + 5'd1);
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lag_subtractor.sv
// -----------------------------------------------------------------------------
// tb_lag_subtractor
// Directed bench for lag_subtractor: reset state, lag differencing, sign
// extension, backpressure, pointer wrap with lag clamping, lag 0 bypass,
// clear with a colliding sample, and an asynchronous mid-cycle reset.
// -----------------------------------------------------------------------------
module tb_lag_subtractor;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic [4:0]  lag;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_warm;

  int checks   = 0;
  int failures = 0;

  lag_subtractor #(
    .DATA_W(8), .OUT_W(16), .MAX_LAG(16), .DEFAULT_LAG(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .lag(lag),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_warm(out_warm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Offer one sample and advance past the edge that accepts it.
  task automatic step_sample(input int x);
    in_data  = 8'(x);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear(input int l);
    in_valid = 1'b0;
    clear    = 1'b1;
    lag      = 5'(l);
    @(posedge clk);
    #1;
    clear = 1'b0;
    lag   = 5'd0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'h0000 || out_warm !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got valid=%b data=%h warm=%b, want 0/0000/0",
               out_valid, out_data, out_warm);
    end
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    $display("[%0t] reset done", $time);
  endtask

  task automatic test_basic();
    int xs [4] = '{5, 7, -3, 100};
    int ys [4] = '{5, 2, -10, 103};
    logic ws [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      in_data  = 8'(xs[i]);
      in_valid = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL basic_in_ready[%0d]: got %b want 1", i, in_ready);
      end
      step_sample(xs[i]);
      $display("[%0t] basic x=%0d y=%h warm=%b", $time, xs[i], out_data, out_warm);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'(ys[i]) || out_warm !== ws[i]) begin
        failures++;
        $display("FAIL basic_y[%0d]: got valid=%b y=%h warm=%b, want 1/%h/%b",
                 i, out_valid, out_data, out_warm, 16'(ys[i]), ws[i]);
      end
    end
    idle_cycle();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_drain: out_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_lag3();
    do_clear(3);
    for (int i = 0; i < 8; i++) begin
      step_sample(i + 1);
      $display("[%0t] lag3 x=%0d y=%h warm=%b", $time, i + 1, out_data, out_warm);
      checks++;
      if (out_data !== 16'((i < 3) ? (i + 1) : 3) || out_warm !== (i >= 3)) begin
        failures++;
        $display("FAIL lag3_y[%0d]: got y=%h warm=%b, want %h/%b", i, out_data,
                 out_warm, 16'((i < 3) ? (i + 1) : 3), (i >= 3));
      end
    end
    idle_cycle();
  endtask

  task automatic test_extremes();
    do_clear(1);
    step_sample(-128);
    step_sample(127);
    $display("[%0t] extremes -128,127 y=%h", $time, out_data);
    checks++;
    if (out_data !== 16'h00FF) begin
      failures++;
      $display("FAIL extreme_pos: got %h want 00ff", out_data);
    end
    do_clear(1);
    step_sample(127);
    step_sample(-128);
    $display("[%0t] extremes 127,-128 y=%h", $time, out_data);
    checks++;
    if (out_data !== 16'hFF01) begin
      failures++;
      $display("FAIL extreme_neg: got %h want ff01", out_data);
    end
    idle_cycle();
  endtask

  task automatic test_backpressure();
    do_clear(1);
    out_ready = 1'b1;
    step_sample(10);
    out_ready = 1'b0;
    in_data   = 8'd25;
    in_valid  = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 16'd10) begin
        failures++;
        $display("FAIL bp_hold[%0d]: got ready=%b valid=%b y=%h, want 0/1/000a",
                 i, in_ready, out_valid, out_data);
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release_ready: got %b want 1", in_ready);
    end
    @(posedge clk);
    #1;
    $display("[%0t] backpressure x=25 y=%h", $time, out_data);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'd15 || out_warm !== 1'b1) begin
      failures++;
      $display("FAIL bp_release_y: got valid=%b y=%h warm=%b, want 1/000f/1",
               out_valid, out_data, out_warm);
    end
    step_sample(26);
    $display("[%0t] backpressure x=26 y=%h", $time, out_data);
    checks++;
    if (out_data !== 16'd1) begin
      failures++;
      $display("FAIL bp_next_y: got %h want 0001", out_data);
    end
    idle_cycle();
  endtask

  task automatic test_wrap_clamp();
    do_clear(20);
    for (int i = 0; i < 40; i++) begin
      step_sample(i);
      $display("[%0t] wrap x=%0d y=%h warm=%b", $time, i, out_data, out_warm);
      checks++;
      if (out_data !== 16'((i < 16) ? i : 16) || out_warm !== (i >= 16)) begin
        failures++;
        $display("FAIL wrap_y[%0d]: got y=%h warm=%b, want %h/%b", i, out_data,
                 out_warm, 16'((i < 16) ? i : 16), (i >= 16));
      end
    end
    do_clear(0);
    for (int i = 0; i < 3; i++) begin
      step_sample((i == 0) ? 9 : ((i == 1) ? -4 : 50));
      $display("[%0t] lag0 y=%h warm=%b", $time, out_data, out_warm);
      checks++;
      if (out_data !== 16'((i == 0) ? 9 : ((i == 1) ? -4 : 50)) || out_warm !== 1'b0) begin
        failures++;
        $display("FAIL lag0_y[%0d]: got y=%h warm=%b, want %h/0", i, out_data,
                 out_warm, 16'((i == 0) ? 9 : ((i == 1) ? -4 : 50)));
      end
    end
    idle_cycle();
  endtask

  task automatic test_clear_collision();
    do_clear(1);
    step_sample(3);
    step_sample(8);
    in_data  = 8'd77;
    in_valid = 1'b1;
    clear    = 1'b1;
    lag      = 5'd1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL clear_in_ready: got %b want 0", in_ready);
    end
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL clear_drop: out_valid got %b want 0", out_valid);
    end
    step_sample(40);
    $display("[%0t] after clear x=40 y=%h warm=%b", $time, out_data, out_warm);
    checks++;
    if (out_data !== 16'd40 || out_warm !== 1'b0) begin
      failures++;
      $display("FAIL clear_restart: got y=%h warm=%b want 0028/0", out_data, out_warm);
    end
    idle_cycle();
  endtask

  task automatic test_async_reset();
    do_clear(3);
    step_sample(50);
    step_sample(60);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'h0000 || out_warm !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: got valid=%b y=%h warm=%b, want 0/0000/0",
               out_valid, out_data, out_warm);
    end
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step_sample(7);
    step_sample(9);
    $display("[%0t] post-reset x=9 y=%h warm=%b", $time, out_data, out_warm);
    checks++;
    if (out_data !== 16'd2 || out_warm !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_lag: got y=%h warm=%b want 0002/1", out_data, out_warm);
    end
    idle_cycle();
  endtask

  initial begin
    rst_n     = 1'b1;
    clear     = 1'b0;
    lag       = 5'd0;
    in_valid  = 1'b0;
    in_data   = 8'd0;
    out_ready = 1'b1;
    #2;
    test_reset();
    test_basic();
    test_lag3();
    test_extremes();
    test_backpressure();
    test_wrap_clamp();
    test_clear_collision();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
